// File: rtl/wb_master_engine.sv
// Wishbone classic master: runs one queued write/read/compare at a time with
// pre-cycle delay, rty retries, per-attempt timeout and a status response.
`timescale 1ns/1ps
module wb_master_engine #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 32,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [1:0]          i_cmd_op,
    input  logic [AWIDTH-1:0]   i_cmd_adr,
    input  logic [DWIDTH-1:0]   i_cmd_dat,
    input  logic [DWIDTH/8-1:0] i_cmd_sel,
    input  logic [7:0]          i_cmd_delay,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DWIDTH-1:0]   o_rsp_dat,
    output logic [2:0]          o_rsp_status,
    output logic                o_busy,
    output logic [AWIDTH-1:0]   o_adr,
    output logic [DWIDTH-1:0]   o_dout,
    input  logic [DWIDTH-1:0]   i_din,
    output logic                o_cyc,
    output logic                o_stb,
    output logic                o_we,
    output logic [DWIDTH/8-1:0] o_sel,
    input  logic                i_ack,
    input  logic                i_err,
    input  logic                i_rty
);

    localparam int SW = DWIDTH / 8;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] ST_OK        = 3'd0;
    localparam logic [2:0] ST_ERR       = 3'd1;
    localparam logic [2:0] ST_RETRY_EXH = 3'd2;
    localparam logic [2:0] ST_TIMEOUT   = 3'd3;
    localparam logic [2:0] ST_MISMATCH  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_ACTIVE,
        S_GAP,
        S_RESP
    } state_t;

    state_t              r_state, w_state;
    logic                r_is_write, w_is_write;
    logic                r_is_cmp, w_is_cmp;
    logic [AWIDTH-1:0]   r_cadr, w_cadr;
    logic [DWIDTH-1:0]   r_cdat, w_cdat;
    logic [SW-1:0]       r_csel, w_csel;
    logic [7:0]          r_dcnt, w_dcnt;
    logic [RW-1:0]       r_retry, w_retry;
    logic [TW-1:0]       r_tcnt, w_tcnt;
    logic                r_cmd_ready, w_cmd_ready;
    logic                r_rsp_valid, w_rsp_valid;
    logic [DWIDTH-1:0]   r_rsp_dat, w_rsp_dat;
    logic [2:0]          r_rsp_status, w_rsp_status;
    logic                r_busy, w_busy;
    logic [AWIDTH-1:0]   r_adr, w_adr;
    logic [DWIDTH-1:0]   r_dout, w_dout;
    logic                r_cyc, w_cyc;
    logic                r_we, w_we;
    logic [SW-1:0]       r_sel, w_sel;
    logic                w_launch;
    logic                w_drop;
    logic                w_mismatch;

    // A compare fails if any enabled byte lane of the read data differs.
    always_comb begin
        w_mismatch = 1'b0;
        for (int b = 0; b < SW; b++) begin
            if (r_csel[b] && (i_din[8*b +: 8] != r_cdat[8*b +: 8])) begin
                w_mismatch = 1'b1;
            end
        end
    end

    always_comb begin
        w_state      = r_state;
        w_is_write   = r_is_write;
        w_is_cmp     = r_is_cmp;
        w_cadr       = r_cadr;
        w_cdat       = r_cdat;
        w_csel       = r_csel;
        w_dcnt       = r_dcnt;
        w_retry      = r_retry;
        w_tcnt       = r_tcnt;
        w_cmd_ready  = r_cmd_ready;
        w_rsp_valid  = r_rsp_valid;
        w_rsp_dat    = r_rsp_dat;
        w_rsp_status = r_rsp_status;
        w_adr        = r_adr;
        w_dout       = r_dout;
        w_cyc        = r_cyc;
        w_we         = r_we;
        w_sel        = r_sel;
        w_launch     = 1'b0;
        w_drop       = 1'b0;

        case (r_state)
            // Every command passes through DELAY, so cyc rises delay+1 edges after acceptance.
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_is_write  = (i_cmd_op == 2'b00);
                    w_is_cmp    = (i_cmd_op == 2'b10);
                    w_cadr      = i_cmd_adr;
                    w_cdat      = i_cmd_dat;
                    w_csel      = i_cmd_sel;
                    w_dcnt      = i_cmd_delay;
                    w_retry     = '0;
                    w_cmd_ready = 1'b0;
                    w_state     = S_DELAY;
                end
            end
            S_DELAY: begin
                if (r_dcnt == 8'd0) begin
                    w_launch = 1'b1;
                end else begin
                    w_dcnt = r_dcnt - 8'd1;
                end
            end
            S_GAP: begin
                w_launch = 1'b1;
            end
            S_ACTIVE: begin
                if (i_err) begin
                    w_drop       = 1'b1;
                    w_rsp_dat    = '0;
                    w_rsp_status = ST_ERR;
                end else if (i_ack) begin
                    w_drop       = 1'b1;
                    w_rsp_dat    = r_is_write ? '0 : i_din;
                    w_rsp_status = (r_is_cmp && w_mismatch) ? ST_MISMATCH : ST_OK;
                end else if (i_rty) begin
                    w_drop = 1'b1;
                    if (r_retry == RW'(MAX_RETRY)) begin
                        w_rsp_dat    = '0;
                        w_rsp_status = ST_RETRY_EXH;
                    end else begin
                        w_retry = r_retry + RW'(1);
                    end
                end else if ((TIMEOUT != 0) && (r_tcnt == TW'(TIMEOUT - 1))) begin
                    w_drop       = 1'b1;
                    w_rsp_dat    = '0;
                    w_rsp_status = ST_TIMEOUT;
                end else begin
                    w_tcnt = r_tcnt + TW'(1);
                end
                // Only a retryable rty goes to GAP; every other drop ends the command.
                if (w_drop) begin
                    if (i_rty && !i_err && !i_ack && (r_retry != RW'(MAX_RETRY))) begin
                        w_state = S_GAP;
                    end else begin
                        w_state     = S_RESP;
                        w_rsp_valid = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_cmd_ready = 1'b1;
                    w_state     = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_launch) begin
            w_state = S_ACTIVE;
            w_tcnt  = '0;
            w_cyc   = 1'b1;
            w_adr   = r_cadr;
            w_sel   = r_csel;
            w_we    = r_is_write;
            w_dout  = r_is_write ? r_cdat : '0;
        end
        if (w_drop) begin
            w_cyc  = 1'b0;
            w_we   = 1'b0;
            w_adr  = '0;
            w_dout = '0;
            w_sel  = '0;
        end
        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_is_write   <= 1'b0;
            r_is_cmp     <= 1'b0;
            r_cadr       <= '0;
            r_cdat       <= '0;
            r_csel       <= '0;
            r_dcnt       <= '0;
            r_retry      <= '0;
            r_tcnt       <= '0;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_status <= ST_OK;
            r_busy       <= 1'b0;
            r_adr        <= '0;
            r_dout       <= '0;
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_sel        <= '0;
        end else begin
            r_state      <= w_state;
            r_is_write   <= w_is_write;
            r_is_cmp     <= w_is_cmp;
            r_cadr       <= w_cadr;
            r_cdat       <= w_cdat;
            r_csel       <= w_csel;
            r_dcnt       <= w_dcnt;
            r_retry      <= w_retry;
            r_tcnt       <= w_tcnt;
            r_cmd_ready  <= w_cmd_ready;
            r_rsp_valid  <= w_rsp_valid;
            r_rsp_dat    <= w_rsp_dat;
            r_rsp_status <= w_rsp_status;
            r_busy       <= w_busy;
            r_adr        <= w_adr;
            r_dout       <= w_dout;
            r_cyc        <= w_cyc;
            r_we         <= w_we;
            r_sel        <= w_sel;
        end
    end

    assign o_cmd_ready  = r_cmd_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_dat    = r_rsp_dat;
    assign o_rsp_status = r_rsp_status;
    assign o_busy       = r_busy;
    assign o_adr        = r_adr;
    assign o_dout       = r_dout;
    assign o_cyc        = r_cyc;
    assign o_stb        = r_cyc;
    assign o_we         = r_we;
    assign o_sel        = r_sel;

endmodule
